// File: rtl/hdmi_tx_hpd_mon.sv
// HDMI TX hot-plug / fault monitor, clk_25m domain.
// Synchronises and debounces the HPD and driver-fault pins, qualifies the sink as connected,
// flags short HPD-low pulses, latches faults and drives the TX output enable.
// Optional build macro: HPD_MON_IRQ_EN enables the sticky event interrupt on irq_o.
module hdmi_tx_hpd_mon #(
  parameter int unsigned DEBOUNCE_CYC = 2500,
  parameter int unsigned PLUG_CYC     = 2_500_000,
  parameter int unsigned UNPLUG_CYC   = 2_500_000
) (
  input  logic       clk_25m,
  input  logic       rst_in,
  input  logic       hpd_i,
  input  logic       fault_n_i,
  input  logic       en_i,
  input  logic       fault_clr_i,
  input  logic       irq_ack_i,
  output logic       connected_o,
  output logic       tx_oe_o,
  output logic       fault_o,
  output logic       plug_evt_o,
  output logic       unplug_evt_o,
  output logic       hpd_pulse_o,
  output logic [7:0] pulse_cnt_o,
  output logic [1:0] state_o,
  output logic       irq_o
);

  localparam int unsigned MaxCyc = (PLUG_CYC > UNPLUG_CYC) ? PLUG_CYC : UNPLUG_CYC;
  localparam int unsigned TimerW = $clog2(MaxCyc + 1);
  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYC);

  typedef enum logic [1:0] {
    StDisc   = 2'd0,
    StArming = 2'd1,
    StConn   = 2'd2,
    StLowChk = 2'd3
  } state_e;

  // Bit 0 carries HPD, bit 1 carries fault_n; fault_n idles high.
  localparam logic [1:0] PinRst = 2'b10;

  (* ASYNC_REG = "TRUE" *) logic [1:0] meta_q, sync_q;
  logic [1:0]           meta_d, sync_d;
  logic [1:0]           db_d, db_q;
  logic [1:0][DbW-1:0]  dcnt_d, dcnt_q;

  state_e              state_d, state_q;
  logic [TimerW-1:0]   timer_d, timer_q;
  logic                connected_d, connected_q;
  logic                plug_d, plug_q;
  logic                unplug_d, unplug_q;
  logic                pulse_d, pulse_q;
  logic [7:0]          pulse_cnt_d, pulse_cnt_q;
  logic                fault_d, fault_q;
  logic                tx_oe_d, tx_oe_q;
  logic                fault_fall;

  // Two-stage synchroniser feed and debounce: a level is accepted only after it
  // has differed from the debounced value for DEBOUNCE_CYC consecutive cycles.
  always_comb begin
    meta_d = {fault_n_i, hpd_i};
    sync_d = meta_q;
    db_d   = db_q;
    dcnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync_q[i] != db_q[i]) begin
        if (dcnt_q[i] == DbW'(DEBOUNCE_CYC - 1)) begin
          db_d[i] = sync_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DbW'(1);
        end
      end
    end
  end

  // Connection FSM with one shared timer; an HPD level exit beats the terminal count.
  always_comb begin
    state_d     = state_q;
    timer_d     = '0;
    plug_d      = 1'b0;
    unplug_d    = 1'b0;
    pulse_d     = 1'b0;
    pulse_cnt_d = pulse_cnt_q;
    unique case (state_q)
      StDisc: begin
        if (db_q[0]) state_d = StArming;
      end
      StArming: begin
        if (!db_q[0]) begin
          state_d = StDisc;
        end else if (timer_q == TimerW'(PLUG_CYC - 1)) begin
          state_d = StConn;
          plug_d  = 1'b1;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StConn: begin
        if (!db_q[0]) state_d = StLowChk;
      end
      StLowChk: begin
        if (db_q[0]) begin
          state_d = StConn;
          pulse_d = 1'b1;
          if (pulse_cnt_q != 8'hff) pulse_cnt_d = pulse_cnt_q + 8'd1;
        end else if (timer_q == TimerW'(UNPLUG_CYC - 1)) begin
          state_d     = StDisc;
          unplug_d    = 1'b1;
          pulse_cnt_d = '0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: state_d = StDisc;
    endcase
    connected_d = (state_d == StConn) || (state_d == StLowChk);
  end

  // Sticky fault (set beats clear, clear only once the pin is healthy) and output enable.
  always_comb begin
    fault_fall = db_q[1] & ~db_d[1];
    fault_d    = fault_q;
    if (fault_clr_i && db_q[1]) fault_d = 1'b0;
    if (fault_fall) fault_d = 1'b1;
    tx_oe_d = connected_q & en_i & ~fault_q;
  end

  // State registers.
  always_ff @(posedge clk_25m or posedge rst_in) begin
    if (rst_in) begin
      meta_q      <= PinRst;
      sync_q      <= PinRst;
      db_q        <= PinRst;
      dcnt_q      <= '0;
      state_q     <= StDisc;
      timer_q     <= '0;
      connected_q <= 1'b0;
      plug_q      <= 1'b0;
      unplug_q    <= 1'b0;
      pulse_q     <= 1'b0;
      pulse_cnt_q <= '0;
      fault_q     <= 1'b0;
      tx_oe_q     <= 1'b0;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      db_q        <= db_d;
      dcnt_q      <= dcnt_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      connected_q <= connected_d;
      plug_q      <= plug_d;
      unplug_q    <= unplug_d;
      pulse_q     <= pulse_d;
      pulse_cnt_q <= pulse_cnt_d;
      fault_q     <= fault_d;
      tx_oe_q     <= tx_oe_d;
    end
  end

`ifdef HPD_MON_IRQ_EN
  logic irq_d, irq_q;

  // Interrupt level: any new event wins over a coincident acknowledge.
  always_comb begin
    irq_d = irq_q;
    if (irq_ack_i) irq_d = 1'b0;
    if (plug_d || unplug_d || pulse_d || (fault_d && !fault_q)) irq_d = 1'b1;
  end

  // Interrupt register.
  always_ff @(posedge clk_25m or posedge rst_in) begin
    if (rst_in) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign irq_o = irq_q;
`else
  logic unused_irq_ack;
  assign unused_irq_ack = irq_ack_i;
  assign irq_o          = 1'b0;
`endif

  assign connected_o  = connected_q;
  assign tx_oe_o      = tx_oe_q;
  assign fault_o      = fault_q;
  assign plug_evt_o   = plug_q;
  assign unplug_evt_o = unplug_q;
  assign hpd_pulse_o  = pulse_q;
  assign pulse_cnt_o  = pulse_cnt_q;
  assign state_o      = state_q;

endmodule
